// File: rtl/cu_pkg.sv
// cu_pkg: opcodes, sequencer states, instruction classes and the control-word layout
package cu_pkg;
   localparam logic [4:0] OP_LD = 5'b00000, OP_LDI = 5'b00001, OP_ST = 5'b00010,
      OP_ADD = 5'b00011, OP_SUB = 5'b00100, OP_SHR = 5'b00101, OP_SHL = 5'b00110,
      OP_AND = 5'b01001, OP_OR = 5'b01010, OP_ADDI = 5'b01011, OP_ANDI = 5'b01100,
      OP_ORI = 5'b01101, OP_MUL = 5'b01110, OP_DIV = 5'b01111, OP_BR = 5'b10010,
      OP_NOP = 5'b11001, OP_HALT = 5'b11010;
   localparam logic [4:0] ALU_ADD = OP_ADD;

   typedef enum logic [3:0] {
      S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_PAUSE, S_HALT
   } state_t;

   typedef enum logic [3:0] {
      C_NOP, C_HALT, C_RALU, C_IMM, C_LDI, C_LD, C_ST, C_MD, C_BR
   } cls_t;

   typedef struct packed {
      logic PCout, Zlowout, ZHighout, MDRout, Cout, BAout;
      logic MARin, PCin, MDRin, IRin, Yin, ZLowIn, ZHighIn, HIin, LOin, CONin;
      logic IncPC, Read, Write;
      logic Gra, Grb, Grc, Rin, Rout;
      logic [4:0] ALU_op;
   } ctrl_t;

   // unlisted opcodes fall into C_NOP
   function automatic cls_t op_class(input logic [4:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL: return C_RALU;
         OP_ADDI, OP_ANDI, OP_ORI:                      return C_IMM;
         OP_LDI:                                        return C_LDI;
         OP_LD:                                         return C_LD;
         OP_ST:                                         return C_ST;
         OP_MUL, OP_DIV:                                return C_MD;
         OP_BR:                                         return C_BR;
         OP_HALT:                                       return C_HALT;
         default:                                       return C_NOP;
      endcase
   endfunction
endpackage

// File: rtl/cu_if.sv
// cu_if: instruction/status inputs and control strobes between sequencer and datapath
interface cu_if;
   import cu_pkg::*;
   logic [31:0] IR;
   logic        branch_flag;
   logic        MemReady;
   logic        Stop;
   ctrl_t       ctrl;
   logic        Run;
   modport master (output IR, branch_flag, MemReady, Stop, input ctrl, Run);
   modport slave  (input IR, branch_flag, MemReady, Stop, output ctrl, Run);
endinterface

// File: rtl/cu_step_decode.sv
// cu_step_decode: combinational map from (step, opcode, branch flag) to control strobes
module cu_step_decode
   import cu_pkg::*;
(
   input  state_t      state_i,
   input  logic [4:0]  op_i,
   input  logic        branch_flag_i,
   output ctrl_t       ctrl_o,
   output logic        run_o
);
   cls_t cl;
   assign cl = op_class(op_i);
   assign run_o = state_i inside {S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7};

   always_comb begin
      ctrl_o = '0;
      case (state_i)
         S_T0: begin
            ctrl_o.PCout = 1'b1; ctrl_o.MARin = 1'b1; ctrl_o.IncPC = 1'b1; ctrl_o.ZLowIn = 1'b1;
         end
         S_T1: begin
            ctrl_o.Zlowout = 1'b1; ctrl_o.PCin = 1'b1; ctrl_o.Read = 1'b1; ctrl_o.MDRin = 1'b1;
         end
         S_T2: begin
            ctrl_o.MDRout = 1'b1; ctrl_o.IRin = 1'b1;
         end
         S_T3: begin
            ctrl_o.Yin   = cl inside {C_RALU, C_IMM, C_LDI, C_LD, C_ST, C_MD};
            ctrl_o.Grb   = cl inside {C_RALU, C_IMM, C_LDI, C_LD, C_ST};
            ctrl_o.BAout = cl inside {C_LDI, C_LD, C_ST};
            ctrl_o.Gra   = cl inside {C_MD, C_BR};
            ctrl_o.Rout  = cl inside {C_RALU, C_IMM, C_MD, C_BR};
            ctrl_o.CONin = cl == C_BR;
         end
         S_T4: begin
            ctrl_o.ZLowIn  = cl inside {C_RALU, C_IMM, C_LDI, C_LD, C_ST, C_MD};
            ctrl_o.Grc     = cl == C_RALU;
            ctrl_o.Grb     = cl == C_MD;
            ctrl_o.Rout    = cl inside {C_RALU, C_MD};
            ctrl_o.Cout    = cl inside {C_IMM, C_LDI, C_LD, C_ST};
            ctrl_o.ZHighIn = cl == C_MD;
            ctrl_o.PCout   = cl == C_BR;
            ctrl_o.Yin     = cl == C_BR;
            ctrl_o.ALU_op  = cl inside {C_RALU, C_IMM, C_MD} ? op_i :
                             cl inside {C_LDI, C_LD, C_ST} ? ALU_ADD : 5'b00000;
         end
         S_T5: begin
            ctrl_o.Zlowout = cl inside {C_RALU, C_IMM, C_LDI, C_LD, C_ST, C_MD};
            ctrl_o.Gra     = cl inside {C_RALU, C_IMM, C_LDI};
            ctrl_o.Rin     = cl inside {C_RALU, C_IMM, C_LDI};
            ctrl_o.MARin   = cl inside {C_LD, C_ST};
            ctrl_o.LOin    = cl == C_MD;
            ctrl_o.Cout    = cl == C_BR;
            ctrl_o.ZLowIn  = cl == C_BR;
            ctrl_o.ALU_op  = cl == C_BR ? ALU_ADD : 5'b00000;
         end
         S_T6: begin
            ctrl_o.Read     = cl == C_LD;
            ctrl_o.MDRin    = cl inside {C_LD, C_ST};
            ctrl_o.Gra      = cl == C_ST;
            ctrl_o.Rout     = cl == C_ST;
            ctrl_o.ZHighout = cl == C_MD;
            ctrl_o.HIin     = cl == C_MD;
            ctrl_o.Zlowout  = cl == C_BR && branch_flag_i;
            ctrl_o.PCin     = cl == C_BR && branch_flag_i;
         end
         S_T7: begin
            ctrl_o.MDRout = cl == C_LD;
            ctrl_o.Gra    = cl == C_LD;
            ctrl_o.Rin    = cl == C_LD;
            ctrl_o.Write  = cl == C_ST;
         end
         default: ctrl_o = '0;
      endcase
   end
endmodule

// File: rtl/control_unit.sv
// control_unit: hardwired fetch/execute sequencer; holds the step register and next-step logic
module control_unit
   import cu_pkg::*;
#(
   parameter bit RESET_PC_STEP = 1'b1
) (
   input logic Clock,
   input logic Clear,
   cu_if.slave bus
);
   state_t     state_q, state_d, bnd;
   cls_t       cl;
   logic [4:0] op;
   logic       unused_ir;

   assign op = bus.IR[31:27];
   assign unused_ir = ^bus.IR[26:0];
   assign cl = op_class(op);
   // Stop is only looked at on the final step of an instruction
   assign bnd = bus.Stop ? S_PAUSE : S_T0;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RESET: state_d = RESET_PC_STEP ? S_T0 : S_PAUSE;
         S_T0:    state_d = S_T1;
         S_T1:    state_d = bus.MemReady ? S_T2 : S_T1;
         S_T2:    state_d = cl == C_HALT ? S_HALT : cl == C_NOP ? bnd : S_T3;
         S_T3:    state_d = S_T4;
         S_T4:    state_d = S_T5;
         S_T5:    state_d = cl inside {C_RALU, C_IMM, C_LDI} ? bnd : S_T6;
         S_T6:    state_d = cl == C_LD ? (bus.MemReady ? S_T7 : S_T6) : cl == C_ST ? S_T7 : bnd;
         S_T7:    state_d = (cl == C_ST && !bus.MemReady) ? S_T7 : bnd;
         S_PAUSE: state_d = bus.Stop ? S_PAUSE : S_T0;
         default: state_d = state_q;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Clear) state_q <= S_RESET;
      else        state_q <= state_d;
   end

   cu_step_decode u_dec (
      .state_i       (state_q),
      .op_i          (op),
      .branch_flag_i (bus.branch_flag),
      .ctrl_o        (bus.ctrl),
      .run_o         (bus.Run)
   );
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: step-program model of the sequencer checked every cycle, plus directed literal checks
module tb_control_unit;
   import cu_pkg::*;

   logic Clock = 1'b0;
   logic Clear = 1'b0;
   cu_if bus ();
   control_unit dut (.Clock(Clock), .Clear(Clear), .bus(bus));
   always #5 Clock = ~Clock;

   int n_cmp = 0, n_err = 0;
   localparam int M_UNK = 0, M_RST = 1, M_RUN = 2, M_PAUSE = 3, M_HALT = 4;
   int mode = M_UNK, idx = 0;

   // Each instruction is a list of steps written as the strobe names asserted in that step
   function automatic string step_str(input logic [4:0] op, input int i);
      string s[8];
      s = '{default: ""};
      s[0] = "PCout MARin IncPC ZLowIn";
      s[1] = "Zlowout PCin Read MDRin";
      s[2] = "MDRout IRin";
      case (op)
         5'b00011, 5'b00100, 5'b01001, 5'b01010, 5'b00101, 5'b00110: begin
            s[3] = "Grb Rout Yin"; s[4] = "Grc Rout ZLowIn OP"; s[5] = "Zlowout Gra Rin";
         end
         5'b01011, 5'b01100, 5'b01101: begin
            s[3] = "Grb Rout Yin"; s[4] = "Cout ZLowIn OP"; s[5] = "Zlowout Gra Rin";
         end
         5'b00001: begin
            s[3] = "Grb BAout Yin"; s[4] = "Cout ZLowIn ADD"; s[5] = "Zlowout Gra Rin";
         end
         5'b00000: begin
            s[3] = "Grb BAout Yin"; s[4] = "Cout ZLowIn ADD"; s[5] = "Zlowout MARin";
            s[6] = "Read MDRin"; s[7] = "MDRout Gra Rin";
         end
         5'b00010: begin
            s[3] = "Grb BAout Yin"; s[4] = "Cout ZLowIn ADD"; s[5] = "Zlowout MARin";
            s[6] = "Gra Rout MDRin"; s[7] = "Write";
         end
         5'b01110, 5'b01111: begin
            s[3] = "Gra Rout Yin"; s[4] = "Grb Rout OP ZHighIn ZLowIn";
            s[5] = "Zlowout LOin"; s[6] = "ZHighout HIin";
         end
         5'b10010: begin
            s[3] = "Gra Rout CONin"; s[4] = "PCout Yin"; s[5] = "Cout ZLowIn ADD"; s[6] = "BRANCH";
         end
         default: ;
      endcase
      return s[i];
   endfunction

   function automatic int step_cnt(input logic [4:0] op);
      case (op)
         5'b00000, 5'b00010: return 8;
         5'b01110, 5'b01111, 5'b10010: return 7;
         5'b00011, 5'b00100, 5'b01001, 5'b01010, 5'b00101, 5'b00110,
         5'b01011, 5'b01100, 5'b01101, 5'b00001: return 6;
         default: return 3;
      endcase
   endfunction

   function automatic bit step_wait(input logic [4:0] op, input int i);
      return i == 1 || (op == 5'b00000 && i == 6) || (op == 5'b00010 && i == 7);
   endfunction

   function automatic ctrl_t mk(input string s, input logic [4:0] op, input bit bf);
      ctrl_t c;
      string t;
      c = '0;
      t = "";
      for (int i = 0; i <= s.len(); i++) begin
         if (i == s.len() || s.substr(i, i) == " ") begin
            case (t)
               "PCout": c.PCout = 1'b1;     "Zlowout": c.Zlowout = 1'b1;
               "ZHighout": c.ZHighout = 1'b1; "MDRout": c.MDRout = 1'b1;
               "Cout": c.Cout = 1'b1;       "BAout": c.BAout = 1'b1;
               "MARin": c.MARin = 1'b1;     "PCin": c.PCin = 1'b1;
               "MDRin": c.MDRin = 1'b1;     "IRin": c.IRin = 1'b1;
               "Yin": c.Yin = 1'b1;         "ZLowIn": c.ZLowIn = 1'b1;
               "ZHighIn": c.ZHighIn = 1'b1; "HIin": c.HIin = 1'b1;
               "LOin": c.LOin = 1'b1;       "CONin": c.CONin = 1'b1;
               "IncPC": c.IncPC = 1'b1;     "Read": c.Read = 1'b1;
               "Write": c.Write = 1'b1;     "Gra": c.Gra = 1'b1;
               "Grb": c.Grb = 1'b1;         "Grc": c.Grc = 1'b1;
               "Rin": c.Rin = 1'b1;         "Rout": c.Rout = 1'b1;
               "OP": c.ALU_op = op;         "ADD": c.ALU_op = 5'b00011;
               "BRANCH": begin c.Zlowout = bf; c.PCin = bf; end
               default: ;
            endcase
            t = "";
         end else t = {t, s.substr(i, i)};
      end
      return c;
   endfunction

   always @(posedge Clock) begin
      if (!Clear) mode <= M_RST;
      else case (mode)
         M_RST: begin mode <= M_RUN; idx <= 0; end
         M_RUN: begin
            if (step_wait(bus.IR[31:27], idx) && !bus.MemReady) idx <= idx;
            else if (idx == 2 && bus.IR[31:27] == 5'b11010) mode <= M_HALT;
            else if (idx == step_cnt(bus.IR[31:27]) - 1) begin
               mode <= bus.Stop ? M_PAUSE : M_RUN;
               idx <= 0;
            end else idx <= idx + 1;
         end
         M_PAUSE: if (!bus.Stop) begin mode <= M_RUN; idx <= 0; end
         default: ;
      endcase
   end

   always @(negedge Clock) begin
      ctrl_t e;
      if (mode != M_UNK) begin
         e = mode == M_RUN ? mk(step_str(bus.IR[31:27], idx), bus.IR[31:27], bus.branch_flag) : '0;
         n_cmp++;
         if ({bus.Run, bus.ctrl} !== {mode == M_RUN, e}) begin
            n_err++;
            $display("FAIL ctrl t=%0t mode=%0d step=%0d got run=%b ctrl=%h exp run=%b ctrl=%h",
                     $time, mode, idx, bus.Run, bus.ctrl, mode == M_RUN, e);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge Clock); #1; end
   endtask

   task automatic run_to_t0(input string nm);
      bit seen = 0;
      for (int k = 0; k < 40 && !seen; k++) begin
         bus.MemReady = (k % 3) != 1;
         tick();
         seen = bus.ctrl.PCout && bus.ctrl.MARin;
      end
      bus.MemReady = 1'b1;
      chk(nm, 32'(seen), 32'd1);
   endtask

   initial begin
      logic [4:0] ops[14];
      ops = '{5'b00001, 5'b00010, 5'b00100, 5'b00101, 5'b00110, 5'b01010, 5'b01011,
              5'b01100, 5'b01101, 5'b01110, 5'b01111, 5'b11001, 5'b10000, 5'b00000};
      bus.IR = 32'h0; bus.branch_flag = 1'b0; bus.MemReady = 1'b1; bus.Stop = 1'b0;
      tick();
      chk("reset_out", {bus.Run, bus.ctrl}, 32'h0);
      tick();
      chk("reset_out2", {bus.Run, bus.ctrl}, 32'h0);
      Clear = 1'b1;
      tick();
      chk("t0_fetch", {bus.ctrl.PCout, bus.ctrl.MARin, bus.ctrl.IncPC, bus.ctrl.ZLowIn, bus.Run}, 5'b11111);
      // and R5,R2,R4
      bus.IR = 32'h4A920000;
      tick(3);
      chk("and_t3", {bus.ctrl.Grb, bus.ctrl.Rout, bus.ctrl.Yin}, 3'b111);
      tick();
      chk("and_t4", {bus.ctrl.Grc, bus.ctrl.Rout, bus.ctrl.ZLowIn, bus.ctrl.ALU_op}, {3'b111, 5'b01001});
      tick();
      chk("and_t5", {bus.ctrl.Zlowout, bus.ctrl.Gra, bus.ctrl.Rin}, 3'b111);
      tick();
      chk("and_len6", {bus.ctrl.PCout, bus.ctrl.MARin}, 2'b11);
      // ld with a slow memory in T6
      bus.IR = 32'h00000000;
      tick(5);
      bus.MemReady = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("ld_t6_hold", {bus.ctrl.Read, bus.ctrl.MDRin}, 2'b11);
         if (i == 3) bus.MemReady = 1'b1;
         tick();
      end
      chk("ld_t7", {bus.ctrl.MDRout, bus.ctrl.Gra, bus.ctrl.Rin, bus.ctrl.Read}, 4'b1110);
      tick();
      chk("ld_back_t0", 32'(bus.ctrl.PCout), 32'd1);
      // br not taken, then taken
      bus.IR = 32'h90000000;
      tick(6);
      chk("br_nt_t6", {bus.Run, bus.ctrl}, {1'b1, 29'h0});
      tick();
      bus.branch_flag = 1'b1;
      tick(6);
      chk("br_t_t6", {bus.ctrl.PCin, bus.ctrl.Zlowout}, 2'b11);
      tick();
      bus.branch_flag = 1'b0;
      // halt
      bus.IR = 32'hD0000000;
      tick(3);
      for (int i = 0; i < 20; i++) begin
         chk("halt_idle", {bus.Run, bus.ctrl}, 32'h0);
         tick();
      end
      Clear = 1'b0;
      tick();
      Clear = 1'b1;
      tick();
      chk("halt_restart", {bus.ctrl.PCout, bus.Run}, 2'b11);
      // Stop raised mid add waits for the boundary
      bus.IR = 32'h18000000;
      tick(4);
      bus.Stop = 1'b1;
      tick();
      chk("stop_t5", {bus.ctrl.Zlowout, bus.ctrl.Gra, bus.ctrl.Rin, bus.Run}, 4'b1111);
      tick();
      chk("pause", {bus.Run, bus.ctrl}, 32'h0);
      bus.Stop = 1'b0;
      tick();
      chk("pause_exit", {bus.ctrl.PCout, bus.Run}, 2'b11);
      tick(4);
      Clear = 1'b0;
      tick();
      chk("clear_mid", {bus.Run, bus.ctrl}, 32'h0);
      Clear = 1'b1;
      tick();
      // remaining instruction classes under a stuttering MemReady
      foreach (ops[i]) begin
         bus.IR = {ops[i], 27'h1234567};
         run_to_t0($sformatf("op_%b_done", ops[i]));
      end
      // Stop on the single-step boundary of a nop
      bus.IR = 32'hC8000000;
      tick(2);
      bus.Stop = 1'b1;
      tick();
      chk("nop_pause", 32'(bus.Run), 32'd0);
      bus.Stop = 1'b0;
      tick(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
